// File: rtl/display_frame_integrator.sv
// display_frame_integrator
//   Receiver for the evaluated pixel frames of the garbled display circuit.
//   For every pixel it counts how many of NB_FRAMES consecutive frames had
//   that pixel lit. It then compares each count with THRESHOLD and sends the
//   recovered bitmap out one row at a time. This is the time averaging a
//   viewer does on screen, done as a testable decoder.
//
//   Ports:
//     i_clk        clock, rising edge
//     i_rst        asynchronous active-high reset
//     i_pix_valid  input row beat valid
//     o_pix_ready  input row beat accepted when valid & ready
//     i_pix_row    one evaluated row, bit i = column i
//     i_pix_last   marks the last row of a frame
//     o_out_valid  decoded row valid
//     i_out_ready  downstream accepts the decoded row
//     o_out_row    decoded bitmap row
//     o_out_last   marks decoded row HEIGHT-1
//     o_frame_err  sticky flag: i_pix_last seen out of place
//     i_watmk      (DISPLAY_INTEG_WATERMARK_EN only) watermark overlay,
//                  bit r*WIDTH+i = row r, column i
//
//   Optional feature macro: DISPLAY_INTEG_WATERMARK_EN. When it is defined,
//   every decoded bit that is set in i_watmk is forced to 0.
module display_frame_integrator #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 8,
  parameter int NB_FRAMES = 8,
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic [WIDTH-1:0]  i_pix_row,
  input  logic              i_pix_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WIDTH-1:0]  o_out_row,
  output logic              o_out_last,
  output logic              o_frame_err
`ifdef DISPLAY_INTEG_WATERMARK_EN
  ,
  input  logic [WIDTH*HEIGHT-1:0] i_watmk
`endif
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [RW-1:0]    LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [RW-1:0]    RW_ONE   = RW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(NB_FRAMES);
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THRESHOLD);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  logic [1:0]       r_state;
  logic [RW-1:0]    r_row_idx;    // also the row being zeroed during CLEAR
  logic [RW-1:0]    r_out_idx;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_row;
  logic             r_out_last;
  logic             r_frame_err;
`ifdef DISPLAY_INTEG_WATERMARK_EN
  logic [HEIGHT-1:0][WIDTH-1:0] r_watmk;
`endif

  logic                        w_accept;
  logic                        w_clear;
  logic                        w_row_end;
  logic [CNT_W-1:0]            w_frame_inc;
  logic [RW-1:0]               w_sel_idx;
  logic [WIDTH-1:0]            w_dec_row;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt [HEIGHT];

  assign w_accept    = i_pix_valid && (r_state == S_ACCUM);
  assign w_clear     = (r_state == S_CLEAR);
  assign w_row_end   = (r_row_idx == LAST_ROW);
  assign w_frame_inc = r_frame_cnt + CNT_ONE;

  // Per-row counter banks. During CLEAR the row under r_row_idx is zeroed.
  // During ACCUM an accepted beat adds into that same row.
  genvar gi;
  generate
    for (gi = 0; gi < HEIGHT; gi++) begin : g_row
      logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
      logic                        w_row_hit;
      assign w_row_hit = (r_row_idx == RW'(gi));
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt <= '0;
        end else if (w_clear && w_row_hit) begin
          r_cnt <= '0;
        end else if (w_accept && w_row_hit) begin
          for (int j = 0; j < WIDTH; j++) begin
            if (i_pix_row[j] && (r_cnt[j] != CNT_MAX))
              r_cnt[j] <= r_cnt[j] + CNT_ONE;
          end
        end
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  // Row to decode next. While a row is being presented, this points at the
  // row after it, so each handshake can load the next row directly.
  assign w_sel_idx = r_out_valid ? (r_out_idx + RW_ONE) : r_out_idx;

  always_comb begin
    w_dec_row = '0;
    for (int j = 0; j < WIDTH; j++) begin
`ifdef DISPLAY_INTEG_WATERMARK_EN
      w_dec_row[j] = (w_cnt[w_sel_idx][j] >= THR_C) & ~r_watmk[w_sel_idx][j];
`else
      w_dec_row[j] = (w_cnt[w_sel_idx][j] >= THR_C);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_CLEAR;
      r_row_idx   <= '0;
      r_out_idx   <= '0;
      r_frame_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef DISPLAY_INTEG_WATERMARK_EN
      r_watmk     <= '0;
`endif
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (w_row_end) begin
            r_row_idx   <= '0;
            r_frame_cnt <= '0;
            r_state     <= S_ACCUM;
          end else begin
            r_row_idx <= r_row_idx + RW_ONE;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (w_row_end && i_pix_last) begin
              r_row_idx   <= '0;
              r_frame_cnt <= w_frame_inc;
              if (w_frame_inc == FRAMES_C) begin
                r_out_idx <= '0;
                r_state   <= S_EMIT;
`ifdef DISPLAY_INTEG_WATERMARK_EN
                r_watmk   <= i_watmk;
`endif
              end
            end else if (w_row_end || i_pix_last) begin
              // The frame is malformed. Its rows stay in the counters, but
              // the frame is not counted, and the next beat starts at row 0.
              r_frame_err <= 1'b1;
              r_row_idx   <= '0;
            end else begin
              r_row_idx <= r_row_idx + RW_ONE;
            end
          end
        end
        S_EMIT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_row   <= w_dec_row;
            r_out_last  <= (r_out_idx == LAST_ROW);
          end else if (i_out_ready) begin
            if (r_out_idx == LAST_ROW) begin
              r_out_valid <= 1'b0;
              r_out_row   <= '0;
              r_out_last  <= 1'b0;
              r_out_idx   <= '0;
              r_row_idx   <= '0;
              r_state     <= S_CLEAR;
            end else begin
              r_out_idx  <= r_out_idx + RW_ONE;
              r_out_row  <= w_dec_row;
              r_out_last <= (w_sel_idx == LAST_ROW);
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign o_pix_ready = (r_state == S_ACCUM);
  assign o_out_valid = r_out_valid;
  assign o_out_row   = r_out_row;
  assign o_out_last  = r_out_last;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_display_frame_integrator.sv
// Directed testbench for display_frame_integrator (WIDTH=16, HEIGHT=8,
// NB_FRAMES=8, THRESHOLD=6). It prints one line per decoded row and one
// summary line at the end.
module tb_display_frame_integrator;
  localparam int W = 16;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic         pix_ready;
  logic [W-1:0] pix_row;
  logic         pix_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_row;
  logic         out_last;
  logic         frame_err;
`ifdef DISPLAY_INTEG_WATERMARK_EN
  logic [W*H-1:0] watmk;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] fr     [8];
  logic [15:0] exp_bm [8];
  int stall_row;

  always #5 clk = ~clk;

  display_frame_integrator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pix_valid (pix_valid),
    .o_pix_ready (pix_ready),
    .i_pix_row   (pix_row),
    .i_pix_last  (pix_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_row   (out_row),
    .o_out_last  (out_last),
    .o_frame_err (frame_err)
`ifdef DISPLAY_INTEG_WATERMARK_EN
    ,
    .i_watmk     (watmk)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!pix_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_timeout"}, 32'(t < 200), 1);
  endtask

  // Called at a negedge. The beat is accepted on the following posedge.
  task automatic send_row(input logic [15:0] row, input logic last);
    wait_ready("send");
    pix_valid = 1'b1;
    pix_row   = row;
    pix_last  = last;
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int r = 0; r < H; r++) send_row(fr[r], r == H - 1);
  endtask

  // Counts the 8 rows that follow one rst edge into CLEAR.
  task automatic check_clear_len(input string tag);
    for (int c = 1; c <= H; c++) begin
      @(negedge clk);
      chk(tag, 32'(pix_ready), 32'(c == H));
    end
  endtask

  task automatic recv_bitmap(input string tag);
    for (int r = 0; r < H; r++) begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk({tag, "_valid_timeout"}, 32'(t < 50), 1);
      chk({tag, "_ready_low_emit"}, 32'(pix_ready), 0);
      if (r == stall_row) begin
        out_ready = 1'b0;
        pix_valid = 1'b1;
        pix_row   = 16'hFFFF;
        pix_last  = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk({tag, "_stall_row"}, 32'(out_row), 32'(exp_bm[r]));
          chk({tag, "_stall_last"}, 32'(out_last), 32'(r == H - 1));
          chk({tag, "_stall_valid"}, 32'(out_valid), 1);
          chk({tag, "_stall_pix_ready"}, 32'(pix_ready), 0);
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
      end
      $display("%s row %0d: out_row=%h out_last=%b", tag, r, out_row, out_last);
      chk({tag, "_row"}, 32'(out_row), 32'(exp_bm[r]));
      chk({tag, "_last"}, 32'(out_last), 32'(r == H - 1));
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
    chk({tag, "_last_drop"}, 32'(out_last), 0);
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_row   = '0;
    pix_last  = 1'b0;
    out_ready = 1'b1;
    stall_row = -1;
`ifdef DISPLAY_INTEG_WATERMARK_EN
    watmk     = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_row", 32'(out_row), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    check_clear_len("clear_len_init");

    // A reset in the middle of ACCUM discards the partial frame.
    send_row(16'hFFFF, 1'b0);
    send_row(16'hFFFF, 1'b0);
    send_row(16'hFFFF, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_pix_ready", 32'(pix_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_row", 32'(out_row), 0);
    chk("midrst_frame_err", 32'(frame_err), 0);
    @(negedge clk);
    rst = 1'b0;
    check_clear_len("clear_len_midrst");

    // 8 identical frames: row 0 = A5A5, with backpressure on output row 4.
    for (int r = 0; r < H; r++) fr[r] = 16'h0000;
    fr[0] = 16'hA5A5;
    for (int f = 0; f < 8; f++) send_frame();
    for (int r = 0; r < H; r++) exp_bm[r] = 16'h0000;
    exp_bm[0] = 16'hA5A5;
    stall_row = 4;
    recv_bitmap("a5a5");
    stall_row = -1;
    chk("a5a5_frame_err", 32'(frame_err), 0);

    // Threshold boundary: pixel (2,3) lit 6 times, pixel (2,4) lit 5 times.
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < H; r++) fr[r] = 16'h0000;
      fr[2] = ((f < 6) ? 16'h0008 : 16'h0000) | ((f < 5) ? 16'h0010 : 16'h0000);
      send_frame();
    end
    for (int r = 0; r < H; r++) exp_bm[r] = 16'h0000;
    exp_bm[2] = 16'h0008;
    recv_bitmap("thresh");

    // Misplaced pix_last on row 2. The rows still accumulate but the
    // frame is not counted.
    send_row(16'hF000, 1'b0);
    send_row(16'h0001, 1'b0);
    send_row(16'h0000, 1'b1);
    chk("misplaced_frame_err", 32'(frame_err), 1);
    for (int f = 0; f < 7; f++) begin
      for (int r = 0; r < H; r++) fr[r] = 16'h0000;
      fr[0] = 16'h0F0F;
      fr[1] = (f < 5) ? 16'h0001 : 16'h0000;
      send_frame();
    end
    chk("misplaced_still_accum", 32'(pix_ready), 1);
    chk("misplaced_no_emit", 32'(out_valid), 0);
    for (int r = 0; r < H; r++) fr[r] = 16'h0000;
    fr[0] = 16'h0F0F;
    send_frame();
    for (int r = 0; r < H; r++) exp_bm[r] = 16'h0000;
    exp_bm[0] = 16'h0F0F;
    exp_bm[1] = 16'h0001;
    recv_bitmap("misplaced");
    chk("frame_err_sticky", 32'(frame_err), 1);

    // Reset clears frame_err. Then all-ones frames with watermark bit 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("frame_err_cleared", 32'(frame_err), 0);
`ifdef DISPLAY_INTEG_WATERMARK_EN
    watmk = 128'h1;
`endif
    for (int r = 0; r < H; r++) fr[r] = 16'hFFFF;
    for (int f = 0; f < 8; f++) send_frame();
    for (int r = 0; r < H; r++) exp_bm[r] = 16'hFFFF;
`ifdef DISPLAY_INTEG_WATERMARK_EN
    exp_bm[0] = 16'hFFFE;
`endif
    recv_bitmap("ones");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
